// File: rtl/parking_sensor_scheduler_pkg.sv
// Shared types and default timing constants for the parking-lot sensor blocks.
package parking_pkg;

    localparam int COUNT_W = 20;

    localparam int DEF_N_SENSORS    = 4;
    localparam int DEF_TRIG_CYCLES  = 1000;
    localparam int DEF_WAIT_TIMEOUT = 100000;
    localparam int DEF_ECHO_MAX     = 1000000;
    localparam int DEF_DETECT_MAX   = 60000;
    localparam int DEF_GAP_CYCLES   = 500000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parking_sensor_scheduler_echo_sync.sv
// N-bit two-flop synchronizer for the raw echo pins, async active-low reset.
module echo_sync
    import parking_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/parking_sensor_scheduler.sv
// Round-robin HC-SR04 scheduler: triggers one bay at a time, times the echo and
// classifies occupancy. Define OCCUPANCY_FILTER_EN to require two agreeing results.
module parking_sensor_scheduler
    import parking_pkg::*;
#(
    parameter int N_SENSORS    = DEF_N_SENSORS,
    parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
    parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT,
    parameter int ECHO_MAX     = DEF_ECHO_MAX,
    parameter int DETECT_MAX   = DEF_DETECT_MAX,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [N_SENSORS-1:0]           echo,
    output logic [N_SENSORS-1:0]           trig,
    output logic [N_SENSORS-1:0]           occupied,
    output logic [4:0]                     free_count,
    output logic                           result_valid,
    output logic [id_width(N_SENSORS)-1:0] result_id,
    output logic [COUNT_W-1:0]             result_time,
    output logic                           result_timeout
);

    localparam int IDW = id_width(N_SENSORS);

    localparam logic [COUNT_W-1:0] TRIG_LAST  = COUNT_W'(TRIG_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WAIT_LAST  = COUNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] ECHO_LAST  = COUNT_W'(ECHO_MAX - 1);
    localparam logic [COUNT_W-1:0] ECHO_SAT   = COUNT_W'(ECHO_MAX);
    localparam logic [COUNT_W-1:0] DETECT_LIM = COUNT_W'(DETECT_MAX);
    localparam logic [COUNT_W-1:0] GAP_LAST   = COUNT_W'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0]     IDX_LAST   = IDW'(N_SENSORS - 1);

    function automatic logic [4:0] free_bays(input logic [N_SENSORS-1:0] occ);
        logic [4:0] n;
        n = 5'(N_SENSORS);
        for (int i = 0; i < N_SENSORS; i++) begin
            n = n - 5'(occ[i]);
        end
        return n;
    endfunction

    logic [N_SENSORS-1:0] echo_s;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]       idx_q, idx_d;
    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic [N_SENSORS-1:0] occupied_q, occupied_d;
    logic [4:0]           free_count_q;
    logic                 valid_q;
    logic [IDW-1:0]       id_q;
    logic [COUNT_W-1:0]   time_q;
    logic                 timeout_q;

    logic                 report;
    logic [COUNT_W-1:0]   rep_time;
    logic                 rep_timeout;
    logic                 rep_occ;

    echo_sync #(
        .W (N_SENSORS)
    ) u_echo_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (echo),
        .q_o    (echo_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            trig_q  <= trig_d;
        end
    end

    // A result is reported exactly on the transition into GAP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        report      = 1'b0;
        rep_time    = '0;
        rep_timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_s[idx_q]) begin
                    state_d = ST_MEASURE;
                    cnt_d   = COUNT_W'(1);
                end else if (cnt_q == WAIT_LAST) begin
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!echo_s[idx_q]) begin
                    state_d  = ST_GAP;
                    cnt_d    = '0;
                    report   = 1'b1;
                    rep_time = cnt_q;
                end else if (cnt_q == ECHO_LAST) begin
                    // Saturate instead of waiting for a stuck echo to fall.
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                    report      = 1'b1;
                    rep_time    = ECHO_SAT;
                    rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = enable ? ST_TRIG : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        trig_d = '0;
        if (state_d == ST_TRIG) begin
            trig_d[idx_d] = 1'b1;
        end
    end

    assign rep_occ = !rep_timeout && (rep_time < DETECT_LIM);

`ifdef OCCUPANCY_FILTER_EN
    logic [N_SENSORS-1:0] pending_q, pending_d;

    // A bay flips only when this result matches the previous one for that bay.
    always_comb begin
        occupied_d = occupied_q;
        pending_d  = pending_q;
        if (report) begin
            pending_d[idx_q] = rep_occ;
            if (pending_q[idx_q] == rep_occ) begin
                occupied_d[idx_q] = rep_occ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    always_comb begin
        occupied_d = occupied_q;
        if (report) begin
            occupied_d[idx_q] = rep_occ;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupied_q   <= '0;
            free_count_q <= 5'(N_SENSORS);
            valid_q      <= 1'b0;
            id_q         <= '0;
            time_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            occupied_q   <= occupied_d;
            free_count_q <= free_bays(occupied_q);
            valid_q      <= report;
            if (report) begin
                id_q      <= idx_q;
                time_q    <= rep_time;
                timeout_q <= rep_timeout;
            end
        end
    end

    assign trig           = trig_q;
    assign occupied       = occupied_q;
    assign free_count     = free_count_q;
    assign result_valid   = valid_q;
    assign result_id      = id_q;
    assign result_time    = time_q;
    assign result_timeout = timeout_q;

endmodule

// File: tb/tb_parking_sensor_scheduler.sv
// Directed bench for parking_sensor_scheduler with short timing parameters.
module tb_parking_sensor_scheduler;

`ifdef OCCUPANCY_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  echo;
    logic [3:0]  trig;
    logic [3:0]  occupied;
    logic [4:0]  free_count;
    logic        result_valid;
    logic [1:0]  result_id;
    logic [19:0] result_time;
    logic        result_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parking_sensor_scheduler #(
        .N_SENSORS    (4),
        .TRIG_CYCLES  (10),
        .WAIT_TIMEOUT (50),
        .ECHO_MAX     (200),
        .DETECT_MAX   (100),
        .GAP_CYCLES   (20)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .echo           (echo),
        .trig           (trig),
        .occupied       (occupied),
        .free_count     (free_count),
        .result_valid   (result_valid),
        .result_id      (result_id),
        .result_time    (result_time),
        .result_timeout (result_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for sensor s to fire, optionally drives its echo, and returns at the
    // negedge where result_valid is first seen.
    task automatic run_sensor(input int s, input int len, input bit stuck, input bit drop_en,
                              output int tw, output int wl, output int fl);
        int k;
        int fall_at;
        tw = 0;
        while (trig == 4'b0 && tw < 400) begin
            @(negedge clk);
            tw++;
        end
        check($sformatf("trig_sel_s%0d", s), 32'(trig), 32'd1 << s);
        k = 0;
        while (trig != 4'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("trig_width_s%0d", s), 32'(k), 32'd10);
        wl      = 0;
        fall_at = -1;
        while (!result_valid && wl < 600) begin
            if (wl == 0 && (len > 0 || stuck)) echo[s] = 1'b1;
            if (!stuck && len > 0 && wl == len) begin
                echo[s] = 1'b0;
                fall_at = wl;
            end
            if (drop_en && wl == 10) enable = 1'b0;
            @(negedge clk);
            wl++;
        end
        check($sformatf("result_valid_s%0d", s), 32'(result_valid), 32'd1);
        check($sformatf("result_id_s%0d", s), 32'(result_id), 32'(s));
        fl = (fall_at >= 0) ? (wl - fall_at) : -1;
        if (stuck) echo[s] = 1'b0;
    endtask

    task automatic post(input string tag, input logic [3:0] occ, input int fc_now, input int fc_next);
        check({tag, "_occ"}, 32'(occupied), 32'(occ));
        check({tag, "_fc_now"}, 32'(free_count), 32'(fc_now));
        @(negedge clk);
        check({tag, "_rv_single"}, 32'(result_valid), 32'd0);
        check({tag, "_fc_next"}, 32'(free_count), 32'(fc_next));
    endtask

    task automatic quiet_sensors_1_to_3();
        int tw, wl, fl;
        for (int s = 1; s < 4; s++) begin
            run_sensor(s, 0, 1'b0, 1'b0, tw, wl, fl);
            check($sformatf("quiet_timeout_s%0d", s), 32'(result_timeout), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tw, wl, fl, k;
        logic idle_ok;

        reset_n = 1'b0;
        enable  = 1'b0;
        echo    = 4'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_occ", 32'(occupied), 32'd0);
        check("rst_fc", 32'(free_count), 32'd4);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_id", 32'(result_id), 32'd0);
        check("rst_time", 32'(result_time), 32'd0);
        check("rst_to", 32'(result_timeout), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Pass A: no echoes anywhere.
        for (int s = 0; s < 4; s++) begin
            run_sensor(s, 0, 1'b0, 1'b0, tw, wl, fl);
            check($sformatf("noecho_lat_s%0d", s), 32'(wl), 32'd50);
            check($sformatf("noecho_to_s%0d", s), 32'(result_timeout), 32'd1);
        end
        post("passA", 4'b0000, 4, 4);

        // Pass B: sensor 1 sees a near object.
        run_sensor(0, 0, 1'b0, 1'b0, tw, wl, fl);
        run_sensor(1, 40, 1'b0, 1'b0, tw, wl, fl);
        check("s1_40_time", 32'(result_time >= 20'd39 && result_time <= 20'd41), 32'd1);
        check("s1_40_to", 32'(result_timeout), 32'd0);
        check("s1_40_fall_lat", 32'(fl), 32'd3);
        post("s1_40", FILT ? 4'b0000 : 4'b0010, 4, FILT ? 4 : 3);
        run_sensor(2, 0, 1'b0, 1'b0, tw, wl, fl);
        run_sensor(3, 0, 1'b0, 1'b0, tw, wl, fl);

        // Pass C: sensor 1 far, sensor 2 stuck high.
        run_sensor(0, 0, 1'b0, 1'b0, tw, wl, fl);
        run_sensor(1, 150, 1'b0, 1'b0, tw, wl, fl);
        check("s1_150_time", 32'(result_time >= 20'd149 && result_time <= 20'd151), 32'd1);
        check("s1_150_to", 32'(result_timeout), 32'd0);
        post("s1_150", 4'b0000, FILT ? 4 : 3, 4);
        run_sensor(2, 0, 1'b1, 1'b0, tw, wl, fl);
        check("s2_stuck_time", 32'(result_time), 32'd200);
        check("s2_stuck_to", 32'(result_timeout), 32'd1);
        post("s2_stuck", 4'b0000, 4, 4);
        run_sensor(3, 0, 1'b0, 1'b0, tw, wl, fl);

        // Pass D: enable dropped while sensor 0 is measuring.
        run_sensor(0, 30, 1'b0, 1'b1, tw, wl, fl);
        check("s0_drop_time", 32'(result_time >= 20'd29 && result_time <= 20'd31), 32'd1);
        check("s0_drop_to", 32'(result_timeout), 32'd0);
        post("s0_drop", FILT ? 4'b0000 : 4'b0001, 4, FILT ? 4 : 3);
        idle_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (trig != 4'b0) idle_ok = 1'b0;
        end
        check("idle_after_drop", 32'(idle_ok), 32'd1);
        enable = 1'b1;
        run_sensor(1, 0, 1'b0, 1'b0, tw, wl, fl);
        check("reenable_first_edge", 32'(tw), 32'd1);

        // Reset pulse in the middle of sensor 2's trigger.
        k = 0;
        while (trig == 4'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("s2_trig_before_reset", 32'(trig), 32'd4);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_trig", 32'(trig), 32'd0);
        check("arst_occ", 32'(occupied), 32'd0);
        check("arst_fc", 32'(free_count), 32'd4);
        check("arst_rv", 32'(result_valid), 32'd0);
        check("arst_id", 32'(result_id), 32'd0);
        check("arst_time", 32'(result_time), 32'd0);
        check("arst_to", 32'(result_timeout), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Sensor 0 readings: occupied, free, occupied, occupied.
        run_sensor(0, 40, 1'b0, 1'b0, tw, wl, fl);
        check("after_reset_first_edge", 32'(tw), 32'd1);
        post("seq1", FILT ? 4'b0000 : 4'b0001, 4, FILT ? 4 : 3);
        quiet_sensors_1_to_3();
        run_sensor(0, 0, 1'b0, 1'b0, tw, wl, fl);
        post("seq2", 4'b0000, FILT ? 4 : 3, 4);
        quiet_sensors_1_to_3();
        run_sensor(0, 40, 1'b0, 1'b0, tw, wl, fl);
        post("seq3", FILT ? 4'b0000 : 4'b0001, 4, FILT ? 4 : 3);
        quiet_sensors_1_to_3();
        run_sensor(0, 40, 1'b0, 1'b0, tw, wl, fl);
        post("seq4", 4'b0001, FILT ? 4 : 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_sensor_scheduler.md
# parking_sensor_scheduler

Time-multiplexed controller for a bank of HC-SR04 ultrasonic sensors, one per parking bay. It fires one sensor at a time in round-robin order so that neighbouring sensors cannot pick up each other's bursts. It measures each echo pulse width in clock cycles and classifies the bay as occupied or free. It sits between the sensor pins and the parking-lot occupancy and display logic, and publishes a per-bay occupancy vector plus a free-bay count.

## Interface
- N_SENSORS, 4: number of sensors/bays, 1..16.
- TRIG_CYCLES, 1000: trigger pulse width in clk cycles (10 µs at 100 MHz).
- WAIT_TIMEOUT, 100000: maximum cycles from trigger end to echo rise.
- ECHO_MAX, 1000000: echo-width saturation limit in cycles; at this limit the result is reported as a timeout.
- DETECT_MAX, 60000: an echo width strictly below this value means the bay is occupied.
- GAP_CYCLES, 500000: settle gap after each measurement, before the next trigger.
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  scanning enable.
- echo  input  N_SENSORS  raw echo pins (asynchronous).
- trig  output  N_SENSORS  trigger pins; at most one bit high at any time.
- occupied  output  N_SENSORS  per-bay occupancy.
- free_count  output  5  N_SENSORS minus popcount(occupied).
- result_valid  output  1  one-cycle strobe when a measurement completes.
- result_id  output  IDW  sensor index of the result; IDW = max(1, $clog2(N_SENSORS)).
- result_time  output  20  measured echo width in cycles.
- result_timeout  output  1  no echo, or echo saturated.

## Operation
- Each echo bit passes through a 2-flop synchronizer. All echo logic uses the synchronized value echo_s.
- Internal state: one shared 20-bit counter and a sensor index idx.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE
  - All trig bits are 0.
  - If enable=1, go to TRIG, counter=0.
- TRIG
  - trig[idx]=1 for exactly TRIG_CYCLES cycles.
  - Then go to WAIT_RISE, counter=0.
  - echo_s is ignored in this state.
- WAIT_RISE
  - If echo_s[idx]=1, go to MEASURE with counter=1.
  - Otherwise, when counter reaches WAIT_TIMEOUT, report a timeout and go to GAP.
- MEASURE
  - The counter increments while echo_s[idx]=1.
  - On echo_s[idx]=0, report result_time=counter with timeout=0, then go to GAP.
  - If the counter reaches ECHO_MAX, report result_time=ECHO_MAX with timeout=1 and go to GAP without waiting for the echo to fall.
- GAP
  - Wait GAP_CYCLES.
  - idx advances, wrapping from N_SENSORS-1 to 0.
  - Then go to TRIG if enable=1, else IDLE.
- Reporting a result (the cycle the FSM enters GAP):
  - result_valid=1, with result_id, result_time and result_timeout registered.
  - occupied[idx] = !timeout && (time < DETECT_MAX).
- enable dropped mid-scan: the current sensor completes through GAP, then the FSM stops in IDLE. idx is retained.
- Widths: all cycle parameters must be < 2^20. The counter never wraps; it saturates at ECHO_MAX.

## Timing
- Reset values: trig=0, occupied=0, free_count=N_SENSORS, result_valid=0, result_id=0, result_time=0, result_timeout=0, idx=0, state=IDLE.
- Reset asserted mid-operation clears every output and register immediately; the trig pulse drops asynchronously.
- Trigger: trig rises on the first clock edge with enable=1 in IDLE, or on GAP exit.
- Echo latency: 2 synchronizer cycles. result_time equals the number of cycles the raw echo was high, ±1.
- result_valid appears 3 cycles after the raw echo falls. It is never high on two consecutive cycles.
- free_count is registered and updates 1 cycle after occupied.
- Sensor period: TRIG_CYCLES + wait + width + GAP_CYCLES + 1.

## Configuration
- OCCUPANCY_FILTER_EN defined: a per-bay 1-bit pending classification is kept. occupied[i] changes only when two consecutive results for bay i agree and differ from the current value.
- Macro undefined: occupied[i] follows every result immediately.
- result_* outputs behave identically in both builds.

## Structure
- Package parking_pkg holds:
  - the state enum typedef;
  - COUNT_W=20;
  - default timing constants shared with the other parking blocks.
- One sub-module: echo_sync, an N-bit 2-flop synchronizer with async active-low reset.

## Test plan
Bench parameters: N_SENSORS=4, TRIG_CYCLES=10, WAIT_TIMEOUT=50, ECHO_MAX=200, DETECT_MAX=100, GAP_CYCLES=20.
- Reset, enable=1, no echoes:
  - trig pulses 10 cycles each in order 0,1,2,3,0.
  - Each result has result_timeout=1 and arrives 50 cycles after trig falls.
  - occupied=0, free_count=4.
- Sensor 1 echo high 40 cycles → result_id=1, result_time=40±1, timeout=0, occupied=4'b0010, then free_count=3.
- Sensor 1 echo high 150 cycles on the next pass → occupied[1]=0, free_count=4.
- Sensor 2 echo stuck high → result_time=200, timeout=1, occupied[2]=0; the scan moves on to sensor 3.
- enable dropped during sensor 0's MEASURE → the result is still reported, then IDLE. Re-enabling triggers sensor 1.
- reset_n pulsed low mid-TRIG → trig=0 at once, all outputs at reset values. After release, sensor 0 is triggered first.
- With OCCUPANCY_FILTER_EN, sensor 0 readings occupied, then free, then occupied → occupied[0] stays 0. Two consecutive occupied readings → 1.
